wave_monitor: RTL and testbench
===============================

# wave_monitor

Sample-stream receiver for the multifunctional wave generator. It consumes the 8-bit waveform sample stream that `tt_um_waves` drives on `uo_out`, and measures one full period per capture. Each capture yields the period in samples and the minimum and maximum sample values. Results leave on a valid/ready port. The block sits on the loopback/measurement side of the design, for self-test and for verifying the generated waveform on silicon.

## Interface
Parameters:
- `SAMPLE_W`, 8, sample width in bits.
- `PERIOD_W`, 16, period counter width.
- `MID`, 128, crossing threshold (unsigned).
- `HYST`, 4, hysteresis half-band (used only with `WAVE_MONITOR_HYST_EN`).

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `ena`  in  1  block enable; low forces IDLE.
- `sample_in`  in  SAMPLE_W  incoming sample.
- `sample_valid`  in  1  `sample_in` valid this cycle. No backpressure: a sample with valid high is always consumed or dropped.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts the result.
- `res_period`  out  PERIOD_W  samples per period.
- `res_min`  out  SAMPLE_W  minimum sample in the window.
- `res_max`  out  SAMPLE_W  maximum sample in the window.
- `res_overflow`  out  1  period counter saturated.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Thresholds: `lo_th` = MID−HYST, `hi_th` = MID+HYST. A sample is "low" if it is < `lo_th` and "high" if it is ≥ `hi_th`.
- Rising crossing: a high sample accepted while the crossing detector is armed. A low sample arms the detector; a crossing disarms it.
- FSM states: IDLE, ARM, SYNC, MEASURE, REPORT.
  - IDLE → ARM when `ena`=1.
  - ARM → SYNC on the first low sample.
  - SYNC → MEASURE on a rising crossing. On entry: cnt=0, min=all-ones, max=0.
  - MEASURE: every valid sample increments cnt and updates min/max.
  - MEASURE → REPORT on a rising crossing. The crossing sample is counted and included in min/max. Outputs latch on this transition.
  - MEASURE → REPORT early if cnt reaches 2^PERIOD_W−1. Outputs latch with `res_period`=all-ones and `res_overflow`=1.
  - REPORT → ARM on `res_valid`&&`res_ready`.
- Samples arriving in IDLE, ARM-before-low, or REPORT are dropped, except that ARM uses them for arming.
- `ena`=0 in any state: IDLE next cycle, `res_valid` deasserts, and any pending result is discarded.
- Arithmetic is unsigned. Min/max are compared over the full SAMPLE_W bits. cnt saturates and never wraps.

## Timing
- Reset values: `res_valid`=0, `res_period`=0, `res_min`=0, `res_max`=0, `res_overflow`=0, `busy`=0, FSM=IDLE.
- Reset mid-measurement fully clears state. No result is emitted.
- Latency: `res_valid` rises the cycle after the closing crossing sample is accepted.
- While `res_valid`=1, all result outputs are stable until the handshake.
- Handshake: `res_valid` falls the cycle after `res_valid`&&`res_ready`. A `res_ready` held high completes the handshake in one cycle.
- `sample_valid` gaps do not affect `res_period`; only valid samples are counted.
- If the closing crossing and cnt saturation coincide, the crossing wins: `res_overflow`=0.

## Configuration
- `WAVE_MONITOR_HYST_EN` defined: thresholds are `lo_th`=MID−HYST and `hi_th`=MID+HYST. Noise of less than HYST around MID never produces a crossing.
- `WAVE_MONITOR_HYST_EN` undefined: `lo_th`=`hi_th`=MID, and `HYST` is ignored. Low means < MID; high means ≥ MID.

## Structure
- Shared package `wave_monitor_pkg` holds:
  - the FSM state enum `wm_state_t`;
  - the default constants `WM_MID` and `WM_HYST`;
  - the result struct `wm_result_t` (period, min, max, overflow).
- One sub-module, `wave_crossing_det`: threshold compare, the arm/disarm flag, and the `rise` pulse output qualified by `sample_valid`.

## Test plan
- **Square wave:** valid every cycle, repeating 5×0x20 then 5×0xE0, `res_ready`=1. Expect `res_period`=10, `res_min`=0x20, `res_max`=0xE0, `res_overflow`=0.
- **Valid gaps:** same square wave with `sample_valid` high every other cycle. Expect identical results, with `res_valid` timing stretched.
- **Backpressure:** hold `res_ready`=0 for 20 cycles after `res_valid`. Outputs stay stable and samples are dropped. Raise `res_ready`: `res_valid` falls next cycle, then the FSM re-arms and produces the next result of 10.
- **Overflow:** with PERIOD_W=6, arm and cross, then hold at 0x00. Expect `res_period`=63 and `res_overflow`=1.
- **Hysteresis:** with HYST_EN defined, alternate 126/130 after arming; expect no result. Rebuild with HYST_EN undefined; expect `res_period`=2.
- **Reset/ena abort:** drop `rst_n` (or `ena`) for 1 cycle in MEASURE. All outputs return to reset values, and no stale result is ever emitted.

Source files
------------

// File: rtl/wave_monitor_pkg.sv
// wave_monitor_pkg: shared types and defaults for the wave_monitor sample-stream receiver.
//   wm_state_t  : capture FSM states
//   WM_MID      : default crossing threshold
//   WM_HYST     : default hysteresis half-band
//   wm_result_t : latched capture result (period, min, max, overflow)
// The result struct is sized for the widest supported configuration
// (PERIOD_W <= WM_PERIOD_W, SAMPLE_W <= WM_SAMPLE_W).
package wave_monitor_pkg;

    localparam int unsigned WM_SAMPLE_W = 8;
    localparam int unsigned WM_PERIOD_W = 16;
    localparam int unsigned WM_MID      = 128;
    localparam int unsigned WM_HYST     = 4;

    typedef enum logic [2:0] {
        WM_IDLE    = 3'd0,
        WM_ARM     = 3'd1,
        WM_SYNC    = 3'd2,
        WM_MEASURE = 3'd3,
        WM_REPORT  = 3'd4
    } wm_state_t;

    typedef struct packed {
        logic [WM_PERIOD_W-1:0] period;
        logic [WM_SAMPLE_W-1:0] min_val;
        logic [WM_SAMPLE_W-1:0] max_val;
        logic                   overflow;
    } wm_result_t;

endpackage

// File: rtl/wave_crossing_det.sv
// wave_crossing_det: threshold compare plus arm/disarm flag for rising-crossing detection.
// A low sample arms the detector; a high sample while armed is a rising crossing and disarms it.
// Configuration macro WAVE_MONITOR_HYST_EN: when defined, low < MID-HYST and high >= MID+HYST;
// otherwise low < MID and high >= MID (HYST ignored).
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   en_i       : detector active; low clears the armed flag
//   sample_i   : incoming sample
//   valid_i    : sample_i valid this cycle
//   low_c      : valid low sample (combinational)
//   rise_c     : rising crossing on this sample (combinational)
module wave_crossing_det
    import wave_monitor_pkg::*;
#(
    parameter int unsigned SAMPLE_W = WM_SAMPLE_W,
    parameter int unsigned MID      = WM_MID,
    parameter int unsigned HYST     = WM_HYST
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en_i,
    input  logic [SAMPLE_W-1:0] sample_i,
    input  logic                valid_i,
    output logic                low_c,
    output logic                rise_c
);

`ifdef WAVE_MONITOR_HYST_EN
    localparam bit HYST_ON = 1'b1;
`else
    localparam bit HYST_ON = 1'b0;
`endif

    // Extra headroom so MID+HYST never wraps against a full-scale sample.
    localparam int unsigned TH_W     = SAMPLE_W + 2;
    localparam int unsigned HYST_EFF = HYST_ON ? HYST : 0;
    localparam int unsigned LO_TH_I  = (MID > HYST_EFF) ? (MID - HYST_EFF) : 0;
    localparam int unsigned HI_TH_I  = MID + HYST_EFF;
    localparam logic [TH_W-1:0] LO_TH = TH_W'(LO_TH_I);
    localparam logic [TH_W-1:0] HI_TH = TH_W'(HI_TH_I);

    logic            armed_q;
    logic            armed_d;
    logic [TH_W-1:0] sample_ext;
    logic            is_low;
    logic            is_high;

    // Unsigned threshold compare.
    always_comb begin
        sample_ext = TH_W'(sample_i);
        is_low     = (sample_ext < LO_TH);
        is_high    = (sample_ext >= HI_TH);
    end

    // Arm on low, fire and disarm on high-while-armed.
    always_comb begin
        armed_d = armed_q;
        low_c   = 1'b0;
        rise_c  = 1'b0;
        if (!en_i) begin
            armed_d = 1'b0;
        end else if (valid_i) begin
            if (armed_q && is_high) begin
                rise_c  = 1'b1;
                armed_d = 1'b0;
            end else if (is_low) begin
                low_c   = 1'b1;
                armed_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            armed_q <= 1'b0;
        end else begin
            armed_q <= armed_d;
        end
    end

endmodule

// File: rtl/wave_monitor.sv
// wave_monitor: measures one full waveform period per capture (sample count, min, max)
// and presents the result on a valid/ready port.
// Configuration macro WAVE_MONITOR_HYST_EN (see wave_crossing_det) enables hysteresis.
// Ports:
//   clk, rst_n    : clock, synchronous active-low reset
//   ena           : block enable; low returns to IDLE and discards any pending result
//   sample_in     : incoming sample, qualified by sample_valid (no backpressure)
//   res_valid     : result available; res_ready accepts it
//   res_period    : valid samples per period (saturates at all-ones)
//   res_min/max   : min / max sample in the measured window
//   res_overflow  : period counter saturated before the closing crossing
//   busy          : high in every state except IDLE
module wave_monitor
    import wave_monitor_pkg::*;
#(
    parameter int unsigned SAMPLE_W = WM_SAMPLE_W,
    parameter int unsigned PERIOD_W = WM_PERIOD_W,
    parameter int unsigned MID      = WM_MID,
    parameter int unsigned HYST     = WM_HYST
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [PERIOD_W-1:0] res_period,
    output logic [SAMPLE_W-1:0] res_min,
    output logic [SAMPLE_W-1:0] res_max,
    output logic                res_overflow,
    output logic                busy
);

    localparam logic [PERIOD_W-1:0] CNT_MAX = '1;

    wm_state_t           state_q, state_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [SAMPLE_W-1:0] min_q, min_d;
    logic [SAMPLE_W-1:0] max_q, max_d;
    wm_result_t          res_q, res_d;
    logic                res_valid_q, res_valid_d;
    logic                busy_q, busy_d;

    logic                det_en_c;
    logic                low_c;
    logic                rise_c;
    logic [PERIOD_W-1:0] cnt_inc_c;
    logic [SAMPLE_W-1:0] min_nx_c;
    logic [SAMPLE_W-1:0] max_nx_c;

    // Detector only tracks samples in the states that consume them; IDLE/REPORT clear it.
    always_comb begin
        det_en_c = ena && ((state_q == WM_ARM) || (state_q == WM_SYNC) ||
                           (state_q == WM_MEASURE));
    end

    wave_crossing_det #(
        .SAMPLE_W (SAMPLE_W),
        .MID      (MID),
        .HYST     (HYST)
    ) u_det (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_i     (det_en_c),
        .sample_i (sample_in),
        .valid_i  (sample_valid),
        .low_c    (low_c),
        .rise_c   (rise_c)
    );

    // Saturating count and running min/max including the current sample.
    always_comb begin
        cnt_inc_c = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + PERIOD_W'(1));
        min_nx_c  = (sample_in < min_q) ? sample_in : min_q;
        max_nx_c  = (sample_in > max_q) ? sample_in : max_q;
    end

    // Next-state and result latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        min_d       = min_q;
        max_d       = max_q;
        res_d       = res_q;
        res_valid_d = res_valid_q;
        busy_d      = 1'b0;

        if (!ena) begin
            state_d     = WM_IDLE;
            cnt_d       = '0;
            min_d       = '1;
            max_d       = '0;
            res_d       = '0;
            res_valid_d = 1'b0;
        end else begin
            case (state_q)
                WM_IDLE: begin
                    state_d = WM_ARM;
                end
                WM_ARM: begin
                    if (low_c) begin
                        state_d = WM_SYNC;
                    end
                end
                WM_SYNC: begin
                    if (rise_c) begin
                        state_d = WM_MEASURE;
                        cnt_d   = '0;
                        min_d   = '1;
                        max_d   = '0;
                    end
                end
                WM_MEASURE: begin
                    if (sample_valid) begin
                        cnt_d = cnt_inc_c;
                        min_d = min_nx_c;
                        max_d = max_nx_c;
                        // Closing crossing wins over a coincident saturation.
                        if (rise_c || (cnt_inc_c == CNT_MAX)) begin
                            state_d        = WM_REPORT;
                            res_valid_d    = 1'b1;
                            res_d.period   = WM_PERIOD_W'(cnt_inc_c);
                            res_d.min_val  = WM_SAMPLE_W'(min_nx_c);
                            res_d.max_val  = WM_SAMPLE_W'(max_nx_c);
                            res_d.overflow = !rise_c;
                        end
                    end
                end
                WM_REPORT: begin
                    if (res_valid_q && res_ready) begin
                        state_d     = WM_ARM;
                        res_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = WM_IDLE;
                end
            endcase
        end

        busy_d = (state_d != WM_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= WM_IDLE;
            cnt_q       <= '0;
            min_q       <= '1;
            max_q       <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            min_q       <= min_d;
            max_q       <= max_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign res_valid    = res_valid_q;
    assign res_period   = PERIOD_W'(res_q.period);
    assign res_min      = SAMPLE_W'(res_q.min_val);
    assign res_max      = SAMPLE_W'(res_q.max_val);
    assign res_overflow = res_q.overflow;
    assign busy         = busy_q;

endmodule

// File: tb/tb_wave_monitor.sv
// tb_wave_monitor: self-checking bench for wave_monitor (default 16-bit counter instance
// plus a 6-bit counter instance for saturation cases).
module tb_wave_monitor;

`ifdef WAVE_MONITOR_HYST_EN
    localparam bit HYST_BUILD = 1'b1;
`else
    localparam bit HYST_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic [7:0]  sample_in;
    logic        sample_valid;
    logic        res_ready;
    logic        res_valid;
    logic [15:0] res_period;
    logic [7:0]  res_min;
    logic [7:0]  res_max;
    logic        res_overflow;
    logic        busy;

    logic        ena6;
    logic [7:0]  s6;
    logic        v6;
    logic        ready6;
    logic        res_valid6;
    logic [5:0]  period6;
    logic [7:0]  min6;
    logic [7:0]  max6;
    logic        ovf6;
    logic        busy6;

    always #5 clk = ~clk;

    wave_monitor #(.SAMPLE_W(8), .PERIOD_W(16), .MID(128), .HYST(4)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .sample_in(sample_in),
        .sample_valid(sample_valid), .res_valid(res_valid), .res_ready(res_ready),
        .res_period(res_period), .res_min(res_min), .res_max(res_max),
        .res_overflow(res_overflow), .busy(busy)
    );

    wave_monitor #(.SAMPLE_W(8), .PERIOD_W(6), .MID(128), .HYST(4)) dut6 (
        .clk(clk), .rst_n(rst_n), .ena(ena6), .sample_in(s6),
        .sample_valid(v6), .res_valid(res_valid6), .res_ready(ready6),
        .res_period(period6), .res_min(min6), .res_max(max6),
        .res_overflow(ovf6), .busy(busy6)
    );

    typedef struct {
        logic [15:0] period;
        logic [7:0]  mn;
        logic [7:0]  mx;
        logic        ovf;
    } exp_t;

    typedef struct {
        logic [7:0]  lo_v;
        logic [7:0]  hi_v;
        int          lo_n;
        int          hi_n;
        int          gap;
        bit          expect_res;
        logic [15:0] period;
        logic [7:0]  mn;
        logic [7:0]  mx;
    } vec_t;

    exp_t        sb_q[$];
    vec_t        vecs[5];
    logic [7:0]  tri_wave[10];
    int          checks   = 0;
    int          failures = 0;
    string       cur_name = "init";
    int          res6_cnt = 0;
    logic [5:0]  cap_period6;
    logic [7:0]  cap_min6;
    logic [7:0]  cap_max6;
    logic        cap_ovf6;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Observe DUT outputs at the falling edge: scoreboard pops on each handshake.
    task automatic observe();
        exp_t e;
        if (res_valid && res_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL %s unexpected_result: got period=%0d min=%02h max=%02h ovf=%0b want none",
                         cur_name, res_period, res_min, res_max, res_overflow);
            end else begin
                e = sb_q.pop_front();
                if ({res_period, res_min, res_max, res_overflow} !== {e.period, e.mn, e.mx, e.ovf}) begin
                    failures++;
                    $display("FAIL %s result: got period=%0d min=%02h max=%02h ovf=%0b want period=%0d min=%02h max=%02h ovf=%0b",
                             cur_name, res_period, res_min, res_max, res_overflow,
                             e.period, e.mn, e.mx, e.ovf);
                end
            end
        end
        if (res_valid6 && ready6) begin
            res6_cnt++;
            cap_period6 = period6;
            cap_min6    = min6;
            cap_max6    = max6;
            cap_ovf6    = ovf6;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [7:0] s, input logic v);
        sample_in    = s;
        sample_valid = v;
        tick();
    endtask

    task automatic put6(input logic [7:0] s, input logic v);
        s6 = s;
        v6 = v;
        tick();
    endtask

    task automatic pad(input int n);
        for (int i = 0; i < n; i++) put(8'h00, 1'b0);
    endtask

    task automatic push(input logic [15:0] p, input logic [7:0] mn, input logic [7:0] mx,
                        input logic ovf);
        exp_t e;
        e.period = p; e.mn = mn; e.mx = mx; e.ovf = ovf;
        sb_q.push_back(e);
    endtask

    // Pulse ena low for one cycle so the FSM is in ARM with a cleared detector.
    task automatic restart();
        ena = 1'b0;
        put(8'h00, 1'b0);
        ena = 1'b1;
        put(8'h00, 1'b0);
    endtask

    task automatic drive_wave(input logic [7:0] lo, input logic [7:0] hi, input int lo_n,
                              input int hi_n, input int gap, input int periods);
        for (int p = 0; p < periods; p++) begin
            for (int i = 0; i < lo_n + hi_n; i++) begin
                put((i < lo_n) ? lo : hi, 1'b1);
                for (int g = 0; g < gap; g++) put(8'($urandom), 1'b0);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int seen;

        vecs[0] = '{8'h20, 8'hE0, 5, 5, 0, 1'b1, 16'd10, 8'h20, 8'hE0};
        vecs[1] = '{8'h20, 8'hE0, 5, 5, 1, 1'b1, 16'd10, 8'h20, 8'hE0};
        vecs[2] = '{8'h00, 8'hFF, 3, 7, 0, 1'b1, 16'd10, 8'h00, 8'hFF};
        vecs[3] = '{8'h7F, 8'h80, 1, 1, 0, !HYST_BUILD, 16'd2, 8'h7F, 8'h80};
        vecs[4] = '{8'h00, 8'h84, 2, 2, 2, 1'b1, 16'd4, 8'h00, 8'h84};
        tri_wave = '{8'h10, 8'h40, 8'h70, 8'hA0, 8'hD0, 8'hF0, 8'hC0, 8'h90, 8'h60, 8'h30};

        rst_n = 1'b0; ena = 1'b0; sample_in = 8'h00; sample_valid = 1'b0; res_ready = 1'b1;
        ena6 = 1'b0; s6 = 8'h00; v6 = 1'b0; ready6 = 1'b1;
        tick(); tick(); tick();
        cur_name = "reset";
        chk("reset_outputs", 64'({res_valid, res_period, res_min, res_max, res_overflow, busy}), 64'd0);
        chk("reset_outputs6", 64'({res_valid6, period6, min6, max6, ovf6, busy6}), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_busy", 64'(busy), 64'd0);
        ena = 1'b1;
        put(8'h00, 1'b0);
        chk("arm_busy", 64'(busy), 64'd1);

        // Table-driven square waves.
        for (int v = 0; v < 5; v++) begin
            cur_name = $sformatf("vec%0d", v);
            restart();
            if (vecs[v].expect_res) push(vecs[v].period, vecs[v].mn, vecs[v].mx, 1'b0);
            drive_wave(vecs[v].lo_v, vecs[v].hi_v, vecs[v].lo_n, vecs[v].hi_n, vecs[v].gap, 2);
            pad(4);
            chk($sformatf("vec%0d_drained", v), 64'(sb_q.size()), 64'd0);
        end

        // Triangle: start crossing excluded, closing crossing included.
        cur_name = "triangle";
        restart();
        push(16'd10, 8'h10, 8'hF0, 1'b0);
        for (int i = 0; i < 20; i++) put(tri_wave[i % 10], 1'b1);
        pad(4);
        chk("tri_drained", 64'(sb_q.size()), 64'd0);

        // Hysteresis band: 126/130 after arming.
        cur_name = "hyst";
        restart();
        if (!HYST_BUILD) for (int i = 0; i < 3; i++) push(16'd2, 8'd126, 8'd130, 1'b0);
        put(8'h00, 1'b1);
        for (int k = 1; k <= 16; k++) put((k % 2 == 1) ? 8'd130 : 8'd126, 1'b1);
        pad(4);
        chk("hyst_drained", 64'(sb_q.size()), 64'd0);

        // Backpressure: result held stable, samples dropped, then re-arm.
        cur_name = "backpressure";
        restart();
        res_ready = 1'b0;
        push(16'd10, 8'h20, 8'hE0, 1'b0);
        drive_wave(8'h20, 8'hE0, 5, 5, 0, 2);
        chk("bp_valid", 64'(res_valid), 64'd1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            put(((i % 10) < 5) ? 8'h20 : 8'hE0, 1'b1);
            if ({res_valid, res_period, res_min, res_max, res_overflow} !==
                {1'b1, 16'd10, 8'h20, 8'hE0, 1'b0}) bad++;
        end
        chk("bp_stable", 64'(bad), 64'd0);
        res_ready = 1'b1;
        put(8'hE0, 1'b1);
        chk("bp_fall", 64'(res_valid), 64'd0);
        push(16'd10, 8'h20, 8'hE0, 1'b0);
        drive_wave(8'h20, 8'hE0, 5, 5, 0, 2);
        pad(4);
        chk("bp_drained", 64'(sb_q.size()), 64'd0);

        // Reset pulse mid-measurement.
        cur_name = "rst_abort";
        restart();
        drive_wave(8'h20, 8'hE0, 5, 5, 0, 1);
        put(8'h20, 1'b1);
        put(8'h20, 1'b1);
        rst_n = 1'b0;
        put(8'h20, 1'b1);
        rst_n = 1'b1;
        chk("rst_abort_clear", 64'({res_valid, res_period, res_min, res_max, res_overflow, busy}), 64'd0);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            put(8'hE0, 1'b1);
            if (res_valid) seen++;
        end
        chk("rst_no_stale", 64'(seen), 64'd0);
        push(16'd10, 8'h20, 8'hE0, 1'b0);
        drive_wave(8'h20, 8'hE0, 5, 5, 0, 2);
        pad(4);
        chk("rst_fresh_drained", 64'(sb_q.size()), 64'd0);

        // ena drop while a result is pending: result discarded.
        cur_name = "ena_abort";
        restart();
        res_ready = 1'b0;
        drive_wave(8'h20, 8'hE0, 5, 5, 0, 2);
        chk("ena_pend_valid", 64'(res_valid), 64'd1);
        ena = 1'b0;
        put(8'h20, 1'b1);
        chk("ena_abort_clear", 64'({res_valid, res_period, res_min, res_max, res_overflow, busy}), 64'd0);
        ena = 1'b1;
        res_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            put(8'hE0, 1'b1);
            if (res_valid) seen++;
        end
        chk("ena_no_stale", 64'(seen), 64'd0);

        // 6-bit counter: saturation, then crossing coincident with saturation.
        cur_name = "overflow";
        sample_valid = 1'b0;
        ena6 = 1'b1;
        put6(8'h00, 1'b0);
        put6(8'h00, 1'b1);
        put6(8'hFF, 1'b1);
        seen = res6_cnt;
        for (int i = 0; i < 63; i++) put6(8'h00, 1'b1);
        put6(8'h00, 1'b0);
        put6(8'h00, 1'b0);
        chk("ovf_count", 64'(res6_cnt - seen), 64'd1);
        chk("ovf_result", 64'({cap_period6, cap_min6, cap_max6, cap_ovf6}),
            64'({6'd63, 8'h00, 8'h00, 1'b1}));
        seen = res6_cnt;
        put6(8'h00, 1'b1);
        put6(8'hFF, 1'b1);
        for (int i = 0; i < 62; i++) put6(8'h00, 1'b1);
        put6(8'hFF, 1'b1);
        put6(8'h00, 1'b0);
        put6(8'h00, 1'b0);
        chk("coincide_count", 64'(res6_cnt - seen), 64'd1);
        chk("coincide_result", 64'({cap_period6, cap_min6, cap_max6, cap_ovf6}),
            64'({6'd63, 8'h00, 8'hFF, 1'b0}));

        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
